serial_frame_tx: RTL

Serialising frame transmitter that sits directly upstream of the serial-input port router. It accepts a parallel request (destination port, data length, data word) and drives the router's serial input line with a complete frame: start bit, 2-bit port number, 4-bit data count, then the data bits. All progress is gated by the shared bit-rate enable `clk_en`, so one frame bit occupies exactly one enabled cycle.

---
 rtl/serial_frame_tx_if.sv | 30 +++
 rtl/serial_frame_tx.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx_if.sv
// Request/status bundle between a frame producer and serial_frame_tx.
// The producer drives the request; the transmitter reports busy/done.
interface serial_frame_tx_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic [1:0]        port_sel;
    logic [3:0]        num_data;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              done;

    modport master (
        output start,
        output port_sel,
        output num_data,
        output data_in,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  port_sel,
        input  num_data,
        input  data_in,
        output busy,
        output done
    );
endinterface

// File: rtl/serial_frame_tx.sv
// Serialises start bit, 2-bit port, 4-bit count and up to 15 data bits
// onto a registered line, one bit per enabled clock.
module serial_frame_tx #(
    parameter int DATA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    serial_frame_tx_if.slave   req,
    output logic               serout
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        PORT,
        CNT,
        DATA,
        FIN
    } state_t;

    state_t      state_q, state_n;
    logic        serout_q, serout_n;
    logic [1:0]  port_sr_q, port_sr_n;
    logic [3:0]  cnt_sr_q, cnt_sr_n;
    logic [14:0] data_sr_q, data_sr_n;
    logic [3:0]  bit_cnt_q, bit_cnt_n;
    logic [3:0]  num_q, num_n;

    // Bits above 14 can never be transmitted.
    if (DATA_W > 15) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^req.data_in[DATA_W-1:15];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            serout_q  <= 1'b1;
            port_sr_q <= '0;
            cnt_sr_q  <= '0;
            data_sr_q <= '0;
            bit_cnt_q <= '0;
            num_q     <= '0;
        end else begin
            state_q   <= state_n;
            serout_q  <= serout_n;
            port_sr_q <= port_sr_n;
            cnt_sr_q  <= cnt_sr_n;
            data_sr_q <= data_sr_n;
            bit_cnt_q <= bit_cnt_n;
            num_q     <= num_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        serout_n  = serout_q;
        port_sr_n = port_sr_q;
        cnt_sr_n  = cnt_sr_q;
        data_sr_n = data_sr_q;
        bit_cnt_n = bit_cnt_q;
        num_n     = num_q;

        unique case (state_q)
            IDLE: begin
                serout_n = 1'b1;
                if (clk_en && req.start) begin
                    state_n   = START;
                    serout_n  = 1'b0;
                    port_sr_n = req.port_sel;
                    cnt_sr_n  = req.num_data;
                    data_sr_n = req.data_in[14:0];
                    num_n     = req.num_data;
                end
            end
            START: begin
                if (clk_en) begin
                    state_n   = PORT;
                    serout_n  = port_sr_q[1];
                    port_sr_n = {port_sr_q[0], 1'b0};
                    bit_cnt_n = 4'd0;
                end
            end
            PORT: begin
                if (clk_en) begin
                    if (bit_cnt_q[0] == 1'b0) begin
                        serout_n  = port_sr_q[1];
                        port_sr_n = {port_sr_q[0], 1'b0};
                        bit_cnt_n = 4'd1;
                    end else begin
                        state_n   = CNT;
                        serout_n  = cnt_sr_q[3];
                        cnt_sr_n  = {cnt_sr_q[2:0], 1'b0};
                        bit_cnt_n = 4'd3;
                    end
                end
            end
            CNT: begin
                if (clk_en) begin
                    if (bit_cnt_q != 4'd0) begin
                        serout_n  = cnt_sr_q[3];
                        cnt_sr_n  = {cnt_sr_q[2:0], 1'b0};
                        bit_cnt_n = bit_cnt_q - 4'd1;
                    end else if (num_q != 4'd0) begin
                        state_n   = DATA;
                        serout_n  = data_sr_q[0];
                        data_sr_n = {1'b0, data_sr_q[14:1]};
                        bit_cnt_n = num_q - 4'd1;
                    end else begin
                        state_n  = FIN;
                        serout_n = 1'b1;
                    end
                end
            end
            DATA: begin
                if (clk_en) begin
                    if (bit_cnt_q != 4'd0) begin
                        serout_n  = data_sr_q[0];
                        data_sr_n = {1'b0, data_sr_q[14:1]};
                        bit_cnt_n = bit_cnt_q - 4'd1;
                    end else begin
                        state_n  = FIN;
                        serout_n = 1'b1;
                    end
                end
            end
            FIN: begin
                // Leaves after one clk even while clk_en is low.
                state_n  = IDLE;
                serout_n = 1'b1;
            end
            default: begin
                state_n  = IDLE;
                serout_n = 1'b1;
            end
        endcase
    end

    assign serout   = serout_q;
    assign req.busy = (state_q != IDLE);
    assign req.done = (state_q == FIN);

endmodule
